// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine transforming COLS_PER_CYCLE columns per clock.
// Build option: define MIXCOL_INV_EN to compile in the inverse datapath (selected per transaction by in_inv).
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data
);

    localparam int GROUPS = 4 / COLS_PER_CYCLE;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST_GROUP = CW'(GROUPS - 1);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [0:127]   work_q, work_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // 2*a0 ^ 3*a1 ^ a2 ^ a3
    function automatic logic [7:0] fwd_row(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3);
        return xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {fwd_row(a0, a1, a2, a3), fwd_row(a1, a2, a3, a0),
                fwd_row(a2, a3, a0, a1), fwd_row(a3, a0, a1, a2)};
    endfunction

`ifdef MIXCOL_INV_EN
    // 14*a0 ^ 11*a1 ^ 13*a2 ^ 9*a3, each multiplier built from the xtime chain 2, 4, 8
    function automatic logic [7:0] inv_row(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] a0_2, a0_4, a0_8, a1_2, a1_8, a2_4, a2_8, a3_8;
        a0_2 = xtime(a0);
        a0_4 = xtime(a0_2);
        a0_8 = xtime(a0_4);
        a1_2 = xtime(a1);
        a1_8 = xtime(xtime(a1_2));
        a2_4 = xtime(xtime(a2));
        a2_8 = xtime(a2_4);
        a3_8 = xtime(xtime(xtime(a3)));
        return (a0_8 ^ a0_4 ^ a0_2) ^ (a1_8 ^ a1_2 ^ a1) ^ (a2_8 ^ a2_4 ^ a2) ^ (a3_8 ^ a3);
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {inv_row(a0, a1, a2, a3), inv_row(a1, a2, a3, a0),
                inv_row(a2, a3, a0, a1), inv_row(a3, a0, a1, a2)};
    endfunction

    logic mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mode_q <= 1'b0;
        else if (state_q == IDLE && in_valid)
            mode_q <= in_inv;
    end
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    // Columns of the current group are rewritten in place; the rest pass through.
    always_comb begin
        // NOTE: work_d gets a full default before the loop so no path leaves it unassigned (no latch).
        work_d = work_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
`ifdef MIXCOL_INV_EN
            work_d[32*(int'(cnt_q)*COLS_PER_CYCLE + j) +: 32] = mode_q
                ? mix_inv(work_q[32*(int'(cnt_q)*COLS_PER_CYCLE + j) +: 32])
                : mix_fwd(work_q[32*(int'(cnt_q)*COLS_PER_CYCLE + j) +: 32]);
`else
            work_d[32*(int'(cnt_q)*COLS_PER_CYCLE + j) +: 32] =
                mix_fwd(work_q[32*(int'(cnt_q)*COLS_PER_CYCLE + j) +: 32]);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_d = BUSY;
            end
            BUSY: begin
                if (cnt_q == LAST_GROUP)
                    state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the working register is reset because it drives out_data, which must read zero after reset.
            work_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q <= in_data;
                        cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    if (cnt_q != LAST_GROUP)
                        cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_data = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: one instance per legal COLS_PER_CYCLE, checked against a GF(2^8) reference.
// Honours MIXCOL_INV_EN the same way as the design.
module tb_mix_columns_seq;

    localparam int NI = 3;  // instance i runs COLS_PER_CYCLE = 1 << i

`ifdef MIXCOL_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [0:127] in_data   [NI];
    logic         in_inv    [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [0:127] out_data  [NI];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .in_inv   (in_inv[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g])
        );
    end

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [0:127] ref_mix(input logic [0:127] s, input bit inv);
        logic [7:0] m [4];
        logic [7:0] a [4];
        logic [7:0] acc;
        logic [0:127] r;
        if (inv) m = '{8'd14, 8'd11, 8'd13, 8'd9};
        else     m = '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[32*c + 8*k +: 8];
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[k], a[(rr + k) % 4]);
                r[32*c + 8*rr +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [0:127] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stimulus helper: one full transaction; lat = -1 if out_valid never rose.
    task automatic do_txn(input int i, input logic [0:127] d, input logic inv,
                          output logic [0:127] res, output int lat);
        int t;
        lat = -1;
        res = 'x;
        t   = 0;
        @(negedge clk);
        while (!in_ready[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        in_inv[i]   = inv;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid[i]) begin
                lat = n;
                break;
            end
        end
        if (lat > 0) begin
            res = out_data[i];
            out_ready[i] = 1'b1;
            @(posedge clk);
            #1;
            out_ready[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = {4{32'hdeadbeef}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (in_ready[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready[%0d]: got %b expected 1", i, in_ready[i]);
            end
            checks++;
            if (out_valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, out_valid[i]);
            end
            checks++;
            if (out_data[i] !== 128'h0) begin
                errors++;
                $display("FAIL reset_out_data[%0d]: got %h expected 0", i, out_data[i]);
            end
        end
        in_valid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (in_ready[i] !== 1'b1 || out_data[i] !== 128'h0) begin
                errors++;
                $display("FAIL post_reset_idle[%0d]: got ready=%b data=%h expected ready=1 data=0",
                         i, in_ready[i], out_data[i]);
            end
        end
    endtask

    task automatic test_forward();
        logic [0:127] vin  [NI];
        logic [0:127] vexp [NI];
        logic [0:127] res;
        int lat;
        vin[0]  = {4{32'hdb135345}};
        vexp[0] = {4{32'h8e4da1bc}};
        vin[1]  = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
        vexp[1] = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
        vin[2]  = vin[1];
        vexp[2] = vexp[1];
        for (int i = 0; i < NI; i++) begin
            do_txn(i, vin[i], 1'b0, res, lat);
            checks++;
            if (res !== vexp[i]) begin
                errors++;
                $display("FAIL forward_data[%0d]: got %h expected %h", i, res, vexp[i]);
            end
            checks++;
            if (lat !== (4 >> i)) begin
                errors++;
                $display("FAIL forward_latency[%0d]: got %0d expected %0d", i, lat, 4 >> i);
            end
        end
    endtask

    task automatic test_inverse();
        logic [0:127] d, res, exp_v;
        int lat;
`ifdef MIXCOL_INV_EN
        for (int i = 0; i < NI; i++) begin
            d = {32'h8e4da1bc, 32'h4d7ebdf8, $urandom, $urandom};
            exp_v = ref_mix(d, 1'b1);
            do_txn(i, d, 1'b1, res, lat);
            checks++;
            if (res[0:63] !== 64'hdb135345_2d26314c) begin
                errors++;
                $display("FAIL inverse_vector[%0d]: got %h expected db1353452d26314c", i, res[0:63]);
            end
            checks++;
            if (res !== exp_v) begin
                errors++;
                $display("FAIL inverse_data[%0d]: got %h expected %h", i, res, exp_v);
            end
            checks++;
            if (lat !== (4 >> i)) begin
                errors++;
                $display("FAIL inverse_latency[%0d]: got %0d expected %0d", i, lat, 4 >> i);
            end
        end
`else
        for (int i = 0; i < NI; i++) begin
            d = {4{32'hdb135345}};
            do_txn(i, d, 1'b1, res, lat);
            checks++;
            if (res !== {4{32'h8e4da1bc}}) begin
                errors++;
                $display("FAIL inv_ignored[%0d]: got %h expected %h", i, res, {4{32'h8e4da1bc}});
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [0:127] s, res, exp_v, back;
        logic inv;
        int lat;
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 16; n++) begin
                s     = rand_state();
                inv   = 1'($urandom_range(0, 1));
                exp_v = ref_mix(s, inv & INV_EN);
                do_txn(i, s, inv, res, lat);
                checks++;
                if (res !== exp_v) begin
                    errors++;
                    $display("FAIL random[%0d.%0d]: got %h expected %h", i, n, res, exp_v);
                end
`ifdef MIXCOL_INV_EN
                do_txn(i, ref_mix(s, 1'b0), 1'b1, back, lat);
                checks++;
                if (back !== s) begin
                    errors++;
                    $display("FAIL round_trip[%0d.%0d]: got %h expected %h", i, n, back, s);
                end
`endif
            end
        end
    endtask

    task automatic test_backpressure();
        logic [0:127] d, exp_v;
        bit seen;
        d     = rand_state();
        exp_v = ref_mix(d, 1'b0);
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = d;
        in_inv[0]   = 1'b0;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid[0];
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_out_valid: got 0 expected 1 within 20 cycles");
        end
        for (int n = 0; n < 10; n++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = rand_state();
            in_inv[0]   = 1'b1;
            @(negedge clk);
            checks++;
            if (out_data[0] !== exp_v || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got data=%h valid=%b ready=%b expected data=%h valid=1 ready=0",
                         n, out_data[0], out_valid[0], in_ready[0], exp_v);
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_data[0] !== exp_v) begin
            errors++;
            $display("FAIL bp_release: got ready=%b valid=%b data=%h expected ready=1 valid=0 data=%h",
                     in_ready[0], out_valid[0], out_data[0], exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:127] exp_q [$];
        int done_cyc [$];
        logic [0:127] d, exp_v;
        int accepted;
        accepted = 0;
        out_ready[1] = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (out_valid[1]) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (out_data[1] !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", cyc, out_data[1], exp_v);
                end
                done_cyc.push_back(cyc);
            end
            if (in_ready[1] && accepted < 6) begin
                d = rand_state();
                in_valid[1] = 1'b1;
                in_data[1]  = d;
                in_inv[1]   = 1'b0;
                exp_q.push_back(ref_mix(d, 1'b0));
                accepted++;
            end else if (in_ready[1]) begin
                in_valid[1] = 1'b0;
            end else begin
                in_data[1] = rand_state();
                in_inv[1]  = 1'b1;
            end
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        checks++;
        if (done_cyc.size() != 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 6", done_cyc.size());
        end
        for (int k = 1; k < done_cyc.size(); k++) begin
            checks++;
            if (done_cyc[k] - done_cyc[k-1] != 4) begin
                errors++;
                $display("FAIL b2b_period[%0d]: got %0d expected 4", k, done_cyc[k] - done_cyc[k-1]);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [0:127] d, res;
        int lat;
        d = rand_state();
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = d;
        in_inv[0]   = 1'b0;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || out_data[0] !== 128'h0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b data=%h ready=%b expected valid=0 data=0 ready=1",
                     out_valid[0], out_data[0], in_ready[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        do_txn(0, d, 1'b0, res, lat);
        checks++;
        if (res !== ref_mix(d, 1'b0) || lat !== 4) begin
            errors++;
            $display("FAIL after_reset_txn: got %h lat %0d expected %h lat 4", res, lat, ref_mix(d, 1'b0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_inv[i]    = 1'b0;
            out_ready[i] = 1'b0;
        end
        test_reset();
        test_forward();
        test_inverse();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequential, parametrised MixColumns / InvMixColumns engine for the AES datapath. It accepts a 128-bit state through a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It supports per-transaction forward or inverse mode and holds the result until downstream accepts it. It sits between the ShiftRows and AddRoundKey stages of the iterative round core, replacing the purely combinational column mixer so that area can be traded against latency.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_inv are valid.
- in_ready  output  1  block can accept a state; high only in IDLE.
- in_data  input  [0:127]  state; column c = bits 32c..32c+31; row r of column c = bits 32c+8r..32c+8r+7 (byte 0 = MSB).
- in_inv  input  1  1 = InvMixColumns, 0 = MixColumns; sampled at accept.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  [0:127]  transformed state, same byte ordering as in_data.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture in_data into the working register, latch in_inv into mode_q, clear the column counter, go to BUSY.
  - BUSY: each cycle, replace columns k*COLS_PER_CYCLE .. k*COLS_PER_CYCLE+COLS_PER_CYCLE-1 of the working register in place, then increment k. After the last group (k = 4/COLS_PER_CYCLE-1), go to DONE.
  - DONE: out_valid=1, out_data = working register. On out_ready, go to IDLE.
- Forward, per column (a0..a3), GF(2^8) modulo x^8+x^4+x^3+x+1:
  - b_r = 2·a_r ^ 3·a_{r+1} ^ a_{r+2} ^ a_{r+3}, indices mod 4.
- Inverse, per column:
  - b_r = 14·a_r ^ 11·a_{r+1} ^ 13·a_{r+2} ^ 9·a_{r+3}.
  - Build from xtime chains: 9 = 8^1, 11 = 8^2^1, 13 = 8^4^1, 14 = 8^4^2.
- xtime(a) = {a[6:0],0} ^ (a[7] ? 8'h1B : 8'h00). All arithmetic is 8-bit; no carries beyond a byte.
- Column counter width = max(1, clog2(4/COLS_PER_CYCLE)). It wraps only via the reload in IDLE and never free-runs.
- in_data and in_inv are ignored outside IDLE. Changing them during BUSY or DONE has no effect.
- out_data is the working register at all times. It is valid only while out_valid=1; in other states it shows partial results.

## Timing
- Reset (asynchronous assert, synchronous to clk on release effect): state=IDLE, out_valid=0, out_data=128'h0, mode_q=0, counter=0.
- in_ready is combinational from state and reads 1 while rst is high. Handshakes during reset are discarded.
- Accept on the edge where in_valid & in_ready. out_valid rises N = 4/COLS_PER_CYCLE edges later: 4, 2 or 1.
- DONE→IDLE on the edge where out_valid & out_ready. in_ready is high the following cycle. There is no accept in the same cycle as output release.
- Throughput: one state per N+2 cycles, assuming out_ready is held high.
- out_ready low: DONE is held indefinitely and out_data stays stable.
- out_ready high before DONE has no effect.
- rst asserted during BUSY or DONE aborts the transaction immediately. The partial result is lost and out_valid drops asynchronously.

## Configuration
- MIXCOL_INV_EN defined: the inverse datapath is compiled in, and in_inv selects the mode per transaction.
- MIXCOL_INV_EN undefined: the inverse multipliers and mode_q are removed. in_inv is ignored and every transaction is forward MixColumns. Port list is unchanged.

## Test plan
- Forward, COLS_PER_CYCLE=1: column db 13 53 45 in all four columns, in_inv=0 → every column 8e 4d a1 bc; out_valid 4 cycles after accept.
- Forward, COLS_PER_CYCLE=4: columns f2 0a 22 5c | 01 01 01 01 | c6 c6 c6 c6 | d4 d4 d4 d5 → 9f dc 58 9d | 01 01 01 01 | c6 c6 c6 c6 | d5 d5 d7 d6; latency 1.
- Inverse, MIXCOL_INV_EN, COLS_PER_CYCLE=2: columns 8e 4d a1 bc | 4d 7e bd f8 | ... → db 13 53 45 | 2d 26 31 4c; latency 2. A forward-then-inverse round trip on 16 random states returns the input.
- Backpressure: out_ready held low for 10 cycles after out_valid → out_data stable, in_ready=0, a new in_valid is ignored. Release out_ready → in_ready=1 the next cycle.
- Reset mid-BUSY (COLS_PER_CYCLE=1, after 2 columns): out_valid=0, out_data=0, in_ready=1. The next transaction produces the correct full result.
- MIXCOL_INV_EN undefined: in_inv=1 with column db 13 53 45 → 8e 4d a1 bc (forward result).
